vector_pipe_control: RTL and testbench
======================================

Name: vector_pipe_control

Overview:
- Next-generation control unit for the vectorized CPU.
- Decodes the 4-bit opcode in Decode and registers the control word into the Execute stage.
- Sequences vector instructions as multiple lane-group passes when VECTOR_LENGTH exceeds the physical LANES.
- Provides decode/stall handshake, flush, and element-base indexing for the vector datapath.

Parameters:
- OPCODE_WIDTH, 4, opcode width. Only the low 4 bits are decoded; higher bits must be 0, else the opcode is treated as NOP.
- VECTOR_LENGTH, 16, architectural elements per vector register.
- LANES, 4, physical ALU lanes. Power of two; must divide VECTOR_LENGTH.
- ALU_CTRL_WIDTH, 3, ALU control width.
- PASSES is derived as VECTOR_LENGTH/LANES.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcodeD  in  OPCODE_WIDTH  opcode in Decode.
- validD  in  1  opcodeD holds a real instruction.
- readyD  out  1  block accepts an instruction this cycle.
- stallE  in  1  Execute back-pressure; hold all E outputs.
- flushE  in  1  kill Execute contents and any sequence in progress.
- validE  out  1  E control word valid.
- isScalarInstructionE, isVectorScalarOperationE, resultSelectorWBE, writeEnableScalarWBE, writeEnableVectorWBE, writeToMemoryEnableME, useInmediateE, outFlagME  out  1 each  registered control bits.
- aluControlE  out  ALU_CTRL_WIDTH  ALU operation.
- laneBaseE  out  $clog2(VECTOR_LENGTH)  first element index of this pass.
- lastPassE  out  1  final (or only) pass of the instruction.
- busyVector  out  1  multi-pass sequence in progress.

Behaviour:
- Decode table, listed as sc/vs/rs/wes/wev/wm/imm/alu/out. Bits not listed are 0; don't-cares are driven as 0.
  - 0000 NOP: all 0.
  - 0001 store: sc wm alu110.
  - 0010 vload: sc rs wev alu110.
  - 0011 scalar-imm: sc wes imm alu111.
  - 0100 out: sc rs out alu110.
  - 0101 sadd: sc wes alu000.
  - 0110 ssub: sc wes alu001.
  - 0111 vadd: wev alu000.
  - 1000 vsub: wev alu001.
  - 1001 vop: wev alu011.
  - 1010 vs-imm: vs wev imm alu010.
  - 1011 cmp: sc alu001.
  - 1100/1101/1110: sc imm alu111.
  - 1111: NOP.
- Instruction classes: an instruction with wev=1 is multi-pass (PASSES passes). All others are single-pass.
- FSM states: IDLE and SEQ. readyD = (state==IDLE) && !stallE, combinational.
- Accept: validD && readyD.
  - Next cycle: validE=1, decoded word, laneBaseE=0.
  - lastPassE=1 if single-pass or PASSES==1; otherwise go to SEQ with passCnt=1 and the opcode latched internally.
- SEQ, each cycle with !stallE: reissue the latched word with laneBaseE=passCnt*LANES.
  - lastPassE=1 when passCnt==PASSES-1, then return to IDLE.
  - Back-to-back accept is possible on the cycle after lastPassE issues.
- IDLE with no accept and !stallE: validE=0 (bubble). The other E outputs keep their previous values.
- stallE=1: all E outputs, passCnt and state hold.
- flushE=1: next cycle validE=0, lastPassE=0, state=IDLE, passCnt=0.
  - Flush overrides stall and any accept; readyD is forced 0 during flush.
- busyVector = (state==SEQ).
- Latency: Decode to E is 1 cycle. A vector op occupies PASSES consecutive unstalled cycles.
- Reset (async, mid-sequence included): state IDLE, passCnt 0, all E outputs 0, busyVector 0. readyD=1 while stallE=0.

Optional Feature:
- Macro: HALT_DETECT_EN.
- Defined:
  - Accepting opcode 1111 enters a sticky HALTED state; extra output port haltedE (1 bit) goes 1.
  - readyD is held 0 until rst_n; validE=0.
  - flushE does not leave HALTED.
- Undefined: 1111 decodes as NOP, accepted normally, and the haltedE port does not exist.

Test Plan:
- Reset with stallE=0 -> all E outputs 0, readyD=1. Then 0101 valid -> next cycle validE=1, wes=1, aluControlE=000, lastPassE=1.
- Defaults, 0111 accepted -> 4 consecutive cycles laneBaseE 0,4,8,12 with wev=1; lastPassE=1 only on 12; readyD=0 for 3 cycles; busyVector=1 for 3 cycles.
- 1010 accepted, stallE=1 for 2 cycles after pass 1 -> laneBaseE holds 4 during the stall, then continues 8,12; total 6 cycles.
- flushE on the cycle laneBaseE=4 -> next cycle validE=0, readyD=1; a following 0110 is accepted and issues alu001.
- PASSES=1 (VECTOR_LENGTH=LANES=4), 1000 accepted -> single cycle, laneBaseE=0, lastPassE=1, busyVector stays 0.
- rst_n asserted mid-sequence -> outputs 0 asynchronously. With HALT_DETECT_EN, 1111 -> haltedE=1 and readyD stays 0 through flushE until reset.

Source files
------------

// File: rtl/vector_pipe_control_if.sv
// Decode/Execute control bundle for vector_pipe_control.
// master: decode/execute side; slave: the control unit. HALT_DETECT_EN adds haltedE.
interface vector_pipe_control_if #(
   parameter int OPCODE_WIDTH   = 4,
   parameter int VECTOR_LENGTH  = 16,
   parameter int ALU_CTRL_WIDTH = 3
);
   localparam int LBW = $clog2(VECTOR_LENGTH);

   logic [OPCODE_WIDTH-1:0]   opcodeD;
   logic                      validD;
   logic                      readyD;
   logic                      stallE;
   logic                      flushE;
   logic                      validE;
   logic                      isScalarInstructionE;
   logic                      isVectorScalarOperationE;
   logic                      resultSelectorWBE;
   logic                      writeEnableScalarWBE;
   logic                      writeEnableVectorWBE;
   logic                      writeToMemoryEnableME;
   logic                      useInmediateE;
   logic                      outFlagME;
   logic [ALU_CTRL_WIDTH-1:0] aluControlE;
   logic [LBW-1:0]            laneBaseE;
   logic                      lastPassE;
   logic                      busyVector;
`ifdef HALT_DETECT_EN
   logic                      haltedE;
`endif

   modport master (
      output opcodeD, validD, stallE, flushE,
      input  readyD, validE, isScalarInstructionE,
      input  isVectorScalarOperationE, resultSelectorWBE,
      input  writeEnableScalarWBE, writeEnableVectorWBE,
      input  writeToMemoryEnableME, useInmediateE, outFlagME,
      input  aluControlE, laneBaseE, lastPassE, busyVector
`ifdef HALT_DETECT_EN
      , input haltedE
`endif
   );

   modport slave (
      input  opcodeD, validD, stallE, flushE,
      output readyD, validE, isScalarInstructionE,
      output isVectorScalarOperationE, resultSelectorWBE,
      output writeEnableScalarWBE, writeEnableVectorWBE,
      output writeToMemoryEnableME, useInmediateE, outFlagME,
      output aluControlE, laneBaseE, lastPassE, busyVector
`ifdef HALT_DETECT_EN
      , output haltedE
`endif
   );
endinterface

// File: rtl/vector_pipe_control.sv
// Vector control unit: decodes opcodeD into a registered E control word and
// replays vector ops as VECTOR_LENGTH/LANES lane-group passes.
// Ports: clk, rst_n (async, active low), bus (vector_pipe_control_if.slave):
//   opcodeD/validD/readyD decode handshake, stallE/flushE execute control,
//   E control word, laneBaseE, lastPassE, busyVector.
// Optional: HALT_DETECT_EN makes 1111 a sticky halt, reported on haltedE.
module vector_pipe_control #(
   parameter int OPCODE_WIDTH   = 4,
   parameter int VECTOR_LENGTH  = 16,
   parameter int LANES          = 4,
   parameter int ALU_CTRL_WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   vector_pipe_control_if.slave bus
);
   localparam int PASSES = VECTOR_LENGTH / LANES;
   localparam int LBW    = $clog2(VECTOR_LENGTH);
   localparam int PCW    = (PASSES > 1) ? $clog2(PASSES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SEQ, S_HALT} state_t;

   typedef struct packed {
      logic                      sc;
      logic                      vs;
      logic                      rs;
      logic                      wes;
      logic                      wev;
      logic                      wm;
      logic                      imm;
      logic                      outf;
      logic [ALU_CTRL_WIDTH-1:0] alu;
   } ctrl_t;

   state_t           r_state, w_state;
   logic [PCW-1:0]   r_pass, w_pass;
   logic             r_valid, w_valid;
   logic             r_last, w_last;
   logic [LBW-1:0]   r_base, w_base;
   ctrl_t            r_ctrl, w_ctrl;
   ctrl_t            r_seq, w_seq;
   ctrl_t            w_dec;
   logic [OPCODE_WIDTH:0] w_opx;
   logic [3:0]       w_op4;
   logic             w_hi_zero;
   logic             w_halt;
   logic             w_ready;
   logic             w_accept;

   // Zero-extended copy so the upper-bit check needs no empty slice.
   assign w_opx     = {1'b0, bus.opcodeD};
   assign w_op4     = w_opx[3:0];
   assign w_hi_zero = ((w_opx >> 4) == '0);

`ifdef HALT_DETECT_EN
   assign w_halt = w_hi_zero && (w_op4 == 4'hF);
`else
   assign w_halt = 1'b0;
`endif

   always_comb begin
      w_dec = '0;
      if (w_hi_zero) begin
         case (w_op4)
            4'h1: begin w_dec.sc = 1'b1; w_dec.wm = 1'b1;
                        w_dec.alu = ALU_CTRL_WIDTH'(3'b110); end
            4'h2: begin w_dec.sc = 1'b1; w_dec.rs = 1'b1; w_dec.wev = 1'b1;
                        w_dec.alu = ALU_CTRL_WIDTH'(3'b110); end
            4'h3: begin w_dec.sc = 1'b1; w_dec.wes = 1'b1; w_dec.imm = 1'b1;
                        w_dec.alu = ALU_CTRL_WIDTH'(3'b111); end
            4'h4: begin w_dec.sc = 1'b1; w_dec.rs = 1'b1; w_dec.outf = 1'b1;
                        w_dec.alu = ALU_CTRL_WIDTH'(3'b110); end
            4'h5: begin w_dec.sc = 1'b1; w_dec.wes = 1'b1;
                        w_dec.alu = ALU_CTRL_WIDTH'(3'b000); end
            4'h6: begin w_dec.sc = 1'b1; w_dec.wes = 1'b1;
                        w_dec.alu = ALU_CTRL_WIDTH'(3'b001); end
            4'h7: begin w_dec.wev = 1'b1;
                        w_dec.alu = ALU_CTRL_WIDTH'(3'b000); end
            4'h8: begin w_dec.wev = 1'b1;
                        w_dec.alu = ALU_CTRL_WIDTH'(3'b001); end
            4'h9: begin w_dec.wev = 1'b1;
                        w_dec.alu = ALU_CTRL_WIDTH'(3'b011); end
            4'hA: begin w_dec.vs = 1'b1; w_dec.wev = 1'b1; w_dec.imm = 1'b1;
                        w_dec.alu = ALU_CTRL_WIDTH'(3'b010); end
            4'hB: begin w_dec.sc = 1'b1;
                        w_dec.alu = ALU_CTRL_WIDTH'(3'b001); end
            4'hC, 4'hD, 4'hE: begin w_dec.sc = 1'b1; w_dec.imm = 1'b1;
                        w_dec.alu = ALU_CTRL_WIDTH'(3'b111); end
            default: w_dec = '0;
         endcase
      end
   end

   assign w_ready  = (r_state == S_IDLE) && !bus.stallE && !bus.flushE;
   assign w_accept = bus.validD && w_ready;

   always_comb begin
      w_state = r_state;
      w_pass  = r_pass;
      w_valid = r_valid;
      w_last  = r_last;
      w_base  = r_base;
      w_ctrl  = r_ctrl;
      w_seq   = r_seq;
      if (bus.flushE) begin
         // Flush wins over stall and accept, but cannot leave a halt.
         w_valid = 1'b0;
         w_last  = 1'b0;
         w_pass  = '0;
         w_state = (r_state == S_HALT) ? S_HALT : S_IDLE;
      end else if (!bus.stallE) begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept && w_halt) begin
                  w_state = S_HALT;
                  w_valid = 1'b0;
                  w_last  = 1'b0;
               end else if (w_accept) begin
                  w_valid = 1'b1;
                  w_ctrl  = w_dec;
                  w_seq   = w_dec;
                  w_base  = '0;
                  if (w_dec.wev && (PASSES > 1)) begin
                     w_state = S_SEQ;
                     w_pass  = PCW'(1);
                     w_last  = 1'b0;
                  end else begin
                     w_last  = 1'b1;
                  end
               end else begin
                  w_valid = 1'b0;
               end
            end
            S_SEQ: begin
               w_valid = 1'b1;
               w_ctrl  = r_seq;
               w_base  = LBW'(32'(r_pass) * LANES);
               w_last  = (32'(r_pass) == PASSES - 1);
               if (w_last) begin
                  w_state = S_IDLE;
                  w_pass  = '0;
               end else begin
                  w_pass  = PCW'(r_pass + 1'b1);
               end
            end
            S_HALT: w_valid = 1'b0;
            default: w_state = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_pass  <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_base  <= '0;
         r_ctrl  <= '0;
         r_seq   <= '0;
      end else begin
         r_state <= w_state;
         r_pass  <= w_pass;
         r_valid <= w_valid;
         r_last  <= w_last;
         r_base  <= w_base;
         r_ctrl  <= w_ctrl;
         r_seq   <= w_seq;
      end
   end

   assign bus.readyD                   = w_ready;
   assign bus.validE                   = r_valid;
   assign bus.isScalarInstructionE     = r_ctrl.sc;
   assign bus.isVectorScalarOperationE = r_ctrl.vs;
   assign bus.resultSelectorWBE        = r_ctrl.rs;
   assign bus.writeEnableScalarWBE     = r_ctrl.wes;
   assign bus.writeEnableVectorWBE     = r_ctrl.wev;
   assign bus.writeToMemoryEnableME    = r_ctrl.wm;
   assign bus.useInmediateE            = r_ctrl.imm;
   assign bus.outFlagME                = r_ctrl.outf;
   assign bus.aluControlE              = r_ctrl.alu;
   assign bus.laneBaseE                = r_base;
   assign bus.lastPassE                = r_last;
   assign bus.busyVector               = (r_state == S_SEQ);
`ifdef HALT_DETECT_EN
   assign bus.haltedE                  = (r_state == S_HALT);
`endif
endmodule

// File: tb/tb_vector_pipe_control.sv
// Scoreboard bench for vector_pipe_control: a 4-pass and a 1-pass instance
// share the stimulus; per-cycle expectations come from a pass-count model.
module tb_vector_pipe_control;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vector_pipe_control_if #(.OPCODE_WIDTH(4), .VECTOR_LENGTH(16),
                            .ALU_CTRL_WIDTH(3)) b0 ();
   vector_pipe_control_if #(.OPCODE_WIDTH(4), .VECTOR_LENGTH(4),
                            .ALU_CTRL_WIDTH(3)) b1 ();

   vector_pipe_control #(.OPCODE_WIDTH(4), .VECTOR_LENGTH(16),
                         .LANES(4), .ALU_CTRL_WIDTH(3))
      u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   vector_pipe_control #(.OPCODE_WIDTH(4), .VECTOR_LENGTH(4),
                         .LANES(4), .ALU_CTRL_WIDTH(3))
      u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

   typedef struct packed {
      logic        halted;
      logic        ready;
      logic        busy;
      logic        valid;
      logic        last;
      logic [3:0]  base;
      logic [10:0] word;
   } obs_t;

   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   logic mon_en = 1'b0;
   obs_t q0[$];
   obs_t q1[$];

   // Reference model: remaining passes per instance, not an FSM.
   int          passes[2] = '{4, 1};
   logic        m_valid[2], m_last[2], m_halt[2];
   logic [10:0] m_word[2], m_seqw[2];
   int          m_base[2], m_left[2], m_idx[2];

   // Word = {sc,vs,rs,wes,wev,wm,imm,out, alu[2:0]}
   function automatic logic [10:0] dec(input logic [3:0] op);
      case (op)
         4'h1: return {8'b10000100, 3'b110};
         4'h2: return {8'b10101000, 3'b110};
         4'h3: return {8'b10010010, 3'b111};
         4'h4: return {8'b10100001, 3'b110};
         4'h5: return {8'b10010000, 3'b000};
         4'h6: return {8'b10010000, 3'b001};
         4'h7: return {8'b00001000, 3'b000};
         4'h8: return {8'b00001000, 3'b001};
         4'h9: return {8'b00001000, 3'b011};
         4'hA: return {8'b01001010, 3'b010};
         4'hB: return {8'b10000000, 3'b001};
         4'hC, 4'hD, 4'hE: return {8'b10000010, 3'b111};
         default: return 11'd0;
      endcase
   endfunction

   function automatic logic is_halt_op(input logic [3:0] op);
`ifdef HALT_DETECT_EN
      return op == 4'hF;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_valid[k] = 0; m_last[k] = 0; m_halt[k] = 0;
         m_word[k] = '0; m_seqw[k] = '0;
         m_base[k] = 0; m_left[k] = 0; m_idx[k] = 0;
      end
   endtask

   function automatic obs_t model_obs(input int k, input logic st,
                                      input logic fl);
      obs_t o;
      o.halted = m_halt[k];
      o.ready  = !m_halt[k] && (m_left[k] == 0) && !st && !fl;
      o.busy   = m_left[k] > 0;
      o.valid  = m_valid[k];
      o.last   = m_last[k];
      o.base   = 4'(m_base[k]);
      o.word   = m_word[k];
      return o;
   endfunction

   task automatic model_step(input int k, input logic [3:0] op,
                             input logic v, input logic st, input logic fl);
      logic [10:0] d;
      d = dec(op);
      if (fl) begin
         m_valid[k] = 0; m_last[k] = 0; m_left[k] = 0;
      end else if (st) begin
      end else if (m_halt[k]) begin
         m_valid[k] = 0;
      end else if (m_left[k] > 0) begin
         m_valid[k] = 1;
         m_word[k]  = m_seqw[k];
         m_base[k]  = m_idx[k] * 4;
         m_idx[k]++;
         m_left[k]--;
         m_last[k]  = (m_left[k] == 0);
      end else if (v && is_halt_op(op)) begin
         m_halt[k] = 1; m_valid[k] = 0; m_last[k] = 0;
      end else if (v) begin
         m_valid[k] = 1;
         m_word[k]  = d;
         m_base[k]  = 0;
         if (d[6] && passes[k] > 1) begin
            m_seqw[k] = d;
            m_left[k] = passes[k] - 1;
            m_idx[k]  = 1;
            m_last[k] = 0;
         end else begin
            m_last[k] = 1;
         end
      end else begin
         m_valid[k] = 0;
      end
   endtask

   function automatic obs_t sample0();
      obs_t a;
`ifdef HALT_DETECT_EN
      a.halted = b0.haltedE;
`else
      a.halted = 1'b0;
`endif
      a.ready = b0.readyD; a.busy = b0.busyVector;
      a.valid = b0.validE; a.last = b0.lastPassE;
      a.base  = b0.laneBaseE;
      a.word  = {b0.isScalarInstructionE, b0.isVectorScalarOperationE,
                 b0.resultSelectorWBE, b0.writeEnableScalarWBE,
                 b0.writeEnableVectorWBE, b0.writeToMemoryEnableME,
                 b0.useInmediateE, b0.outFlagME, b0.aluControlE};
      return a;
   endfunction

   function automatic obs_t sample1();
      obs_t a;
`ifdef HALT_DETECT_EN
      a.halted = b1.haltedE;
`else
      a.halted = 1'b0;
`endif
      a.ready = b1.readyD; a.busy = b1.busyVector;
      a.valid = b1.validE; a.last = b1.lastPassE;
      a.base  = {2'b00, b1.laneBaseE};
      a.word  = {b1.isScalarInstructionE, b1.isVectorScalarOperationE,
                 b1.resultSelectorWBE, b1.writeEnableScalarWBE,
                 b1.writeEnableVectorWBE, b1.writeToMemoryEnableME,
                 b1.useInmediateE, b1.outFlagME, b1.aluControlE};
      return a;
   endfunction

   // Monitor: one expected observation per instance per cycle.
   always @(negedge clk) begin : monitor
      obs_t a, e;
      if (mon_en) begin
         a = sample0();
         checks++;
         if (q0.size() == 0) begin
            errors++;
            $display("FAIL u0_obs cyc=%0d: no expectation queued", cyc);
         end else begin
            e = q0.pop_front();
            if (a !== e) begin
               errors++;
               $display("FAIL u0_obs cyc=%0d got=%h exp=%h", cyc, a, e);
            end
         end
         a = sample1();
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL u1_obs cyc=%0d: no expectation queued", cyc);
         end else begin
            e = q1.pop_front();
            if (a !== e) begin
               errors++;
               $display("FAIL u1_obs cyc=%0d got=%h exp=%h", cyc, a, e);
            end
         end
      end
   end

   task automatic apply(input logic [3:0] op, input logic v,
                        input logic st, input logic fl);
      b0.opcodeD = op; b0.validD = v; b0.stallE = st; b0.flushE = fl;
      b1.opcodeD = op; b1.validD = v; b1.stallE = st; b1.flushE = fl;
      q0.push_back(model_obs(0, st, fl));
      q1.push_back(model_obs(1, st, fl));
      model_step(0, op, v, st, fl);
      model_step(1, op, v, st, fl);
      cyc++;
   endtask

   task automatic step(input logic [3:0] op, input logic v,
                       input logic st, input logic fl);
      @(posedge clk);
      #1;
      apply(op, v, st, fl);
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      obs_t z;
      z = '0;
      z.ready = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      b0.validD = 0; b0.stallE = 0; b0.flushE = 0; b0.opcodeD = '0;
      b1.validD = 0; b1.stallE = 0; b1.flushE = 0; b1.opcodeD = '0;
      #1;
      chk("rst_async_u0", 32'(sample0()), 32'(z));
      chk("rst_async_u1", 32'(sample1()), 32'(z));
      q0.delete();
      q1.delete();
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      apply(4'h0, 1'b0, 1'b0, 1'b0);
      mon_en = 1'b1;
   endtask

   initial begin
      model_reset();
      do_reset();
      step(4'h5, 1, 0, 0);
      step(4'h0, 0, 0, 0);
      step(4'h7, 1, 0, 0);
      repeat (4) step(4'h0, 0, 0, 0);
      step(4'hA, 1, 0, 0);
      step(4'h0, 0, 0, 0);
      repeat (2) step(4'h0, 0, 1, 0);
      repeat (3) step(4'h0, 0, 0, 0);
      step(4'h7, 1, 0, 0);
      step(4'h0, 0, 0, 0);
      step(4'h0, 0, 0, 1);
      step(4'h6, 1, 0, 0);
      step(4'h0, 0, 0, 0);
      step(4'h8, 1, 0, 0);
      step(4'h0, 0, 0, 0);
      step(4'h9, 1, 0, 0);
      step(4'h0, 0, 0, 0);
      do_reset();
      for (int i = 0; i < 600; i++) begin
         logic [3:0] op;
         op = 4'($urandom_range(0, 15));
         step(op, ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 9) < 2),
              ($urandom_range(0, 19) == 0));
         if (i == 300) do_reset();
      end
      repeat (3) step(4'h0, 0, 0, 0);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
